cam_burst_writer: RTL and testbench
===================================

Name: cam_burst_writer

Overview:
- Downstream of the camera capture stage: consumes the RGB565 pixel stream (write enable plus 16-bit word) and the frame sync.
- Buffers pixels in an internal FIFO and issues fixed-length burst write requests, with linear addresses, to the frame-buffer memory controller.
- Restarts addressing at every frame start and flags frame completion and overflow.

Parameters:
- BURST_LEN, 64: words per burst; must be a power of two; must be ≤ FIFO_DEPTH/2.
- FIFO_DEPTH, 256: FIFO depth in 16-bit words; must be a power of two.
- ADDR_W, 24: memory word-address width.
- BASE_ADDR, 24'd0: frame start address.
- FRAME_PIXELS, 307200: words per frame; must be a multiple of BURST_LEN.

Ports:
- sys_clk  in  1  system clock (pixel stream is synchronous to it)
- sys_rst_n  in  1  reset
- pix_vsync  in  1  camera frame sync, active-high
- pix_wr_en  in  1  pixel valid strobe
- pix_data  in  16  RGB565 pixel
- mem_wr_req  out  1  burst request
- mem_wr_addr  out  ADDR_W  burst start address
- mem_wr_ack  in  1  one-cycle acceptance of the request by the controller
- mem_wr_data_rd  in  1  controller pops one word per asserted cycle
- mem_wr_data  out  16  FIFO head word (first-word fall-through)
- fifo_level  out  log2(FIFO_DEPTH)+1  current word count
- fifo_overflow  out  1  sticky dropped-pixel flag
- frame_done  out  1  one-cycle pulse when a frame's last burst completes

Behaviour:
- Interface: reset sys_rst_n, asynchronous, active-low; clock sys_clk.
- Reset values:
  - mem_wr_req=0, mem_wr_addr=BASE_ADDR, fifo_level=0, fifo_overflow=0, frame_done=0.
  - FSM=IDLE, restart_pending=0, FIFO empty.
  - mem_wr_data is 0 after reset; don't-care whenever the FIFO is empty.
- Frame start: pix_vsync is registered once; a rising edge sets restart_pending.
- Pixel gating: pix_wr_en is ignored while pix_vsync=1.
- Push: pix_wr_en=1 (vsync low) writes pix_data at the edge.
  - Accepted if level<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the pixel is dropped and fifo_overflow is set.
  - fifo_level is registered and reflects the push/pop one cycle later.
  - Simultaneous push and pop leaves the level unchanged.
- FSM states: IDLE, REQ, BURST. mem_wr_req is registered and equals (state==REQ).
- IDLE:
  - If restart_pending: flush FIFO (level=0), address=BASE_ADDR, burst count=0, clear fifo_overflow and restart_pending; stay in IDLE for that cycle.
  - Else if fifo_level≥BURST_LEN: go to REQ.
- REQ:
  - mem_wr_req=1; mem_wr_addr is held stable.
  - mem_wr_ack=1: go to BURST, word counter=0.
  - A vsync rising edge while in REQ with no ack in the same cycle aborts the request: go to IDLE and apply the restart.
  - Ack wins over a same-cycle vsync edge; restart stays pending.
- BURST:
  - Each mem_wr_data_rd pops the head word; the next word appears on mem_wr_data the following cycle.
  - After BURST_LEN pops: go to IDLE and advance mem_wr_addr by BURST_LEN.
  - If the new address equals BASE_ADDR+FRAME_PIXELS: wrap to BASE_ADDR and pulse frame_done for 1 cycle.
  - A vsync edge during BURST is only latched; the burst always completes.
- Pops outside BURST are ignored and do not change the FIFO.
- mem_wr_ack outside REQ is ignored.
- Address arithmetic is modulo 2^ADDR_W.
- Request latency: the 64th word written at edge k gives level=64 after k; the FSM moves to REQ at k+1; mem_wr_req is high after k+1.

Test Plan:
- Reset: hold sys_rst_n=0 with random inputs -> all outputs at reset values, mem_wr_addr=0.
- Single burst: push 64 pixels 0x0000..0x003F on consecutive cycles; ack 3 cycles after req; pop 64 -> req high 2 edges after the last push; req drops after ack; data read in order 0x0000..0x003F; next mem_wr_addr=64; fifo_level=0.
- Frame wrap (FRAME_PIXELS=128): push 128 pixels, serve both bursts -> addresses 0 then 64; frame_done pulses once after the 128th pop; mem_wr_addr returns to 0.
- Overflow: ack held low, push 261 pixels -> fifo_level=256, fifo_overflow=1, pixels 256..260 dropped; then vsync pulse -> req drops, level=0, overflow clears, addr=0.
- Vsync mid-burst: vsync rises after 10 of 64 pops -> burst completes with all 64 words in order; then FIFO flushed and addr=BASE_ADDR; no frame_done pulse.
- Reset mid-burst: deassert sys_rst_n after 20 pops -> immediate return to reset values; a fresh 64-pixel burst afterwards starts at address 0 with correct data.

Source files
------------

// File: rtl/cam_burst_writer.sv
// Buffers the camera pixel stream in a FWFT FIFO and hands it to the frame-buffer
// controller as fixed-length bursts with linear, frame-relative addresses.
module cam_burst_writer #(
  parameter int                BURST_LEN    = 64,
  parameter int                FIFO_DEPTH   = 256,
  parameter int                ADDR_W       = 24,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
  parameter int                FRAME_PIXELS = 307200
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic                          pix_vsync,
  input  logic                          pix_wr_en,
  input  logic [15:0]                   pix_data,
  output logic                          mem_wr_req,
  output logic [ADDR_W-1:0]             mem_wr_addr,
  input  logic                          mem_wr_ack,
  input  logic                          mem_wr_data_rd,
  output logic [15:0]                   mem_wr_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          fifo_overflow,
  output logic                          frame_done
);

  // state | meaning
  // IDLE  | apply a pending frame restart, or wait for a full burst in the FIFO
  // REQ   | burst request raised, address held, waiting for the controller's ack
  // BURST | controller draining BURST_LEN words from the FIFO head
  typedef enum logic [1:0] {IDLE, REQ, BURST} state_t;

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(BURST_LEN) + 1;
  localparam logic [LVL_W-1:0]  DEPTH_L   = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0]  BURST_L   = LVL_W'(BURST_LEN);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] BURST_A   = ADDR_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] FRAME_END = ADDR_W'(BASE_ADDR + ADDR_W'(FRAME_PIXELS));

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic              vsync_q;
  logic              frame_done_q, frame_done_d;
  logic              overflow_q, overflow_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [15:0]       mem_q [FIFO_DEPTH];

  logic vs_rise, flush, pop, push_req, push_ok, drop;

  assign vs_rise  = pix_vsync & ~vsync_q;
  assign addr_nxt = addr_q + BURST_A;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q | vs_rise;
    flush        = 1'b0;
    pop          = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_q) begin
          flush  = 1'b1;
          addr_d = BASE_ADDR;
          pend_d = vs_rise;
        end else if (level_q >= BURST_L) begin
          state_d = REQ;
        end
      end
      REQ: begin
        // ack wins over a same-cycle frame start; the restart then waits for IDLE
        if (mem_wr_ack) begin
          state_d = BURST;
          cnt_d   = CNT_LAST;
        end else if (vs_rise) begin
          state_d = IDLE;
        end
      end
      BURST: begin
        if (mem_wr_data_rd && (level_q != '0)) begin
          pop = 1'b1;
          if (cnt_q == '0) begin
            state_d = IDLE;
            if (addr_nxt == FRAME_END) begin
              addr_d       = BASE_ADDR;
              frame_done_d = 1'b1;
            end else begin
              addr_d = addr_nxt;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A full FIFO still takes a pixel when the controller pops in the same cycle.
  always_comb begin
    push_req   = pix_wr_en & ~pix_vsync;
    push_ok    = push_req & ~flush & ((level_q != DEPTH_L) | pop);
    drop       = push_req & ~flush & ~push_ok;
    overflow_d = flush ? 1'b0 : (overflow_q | drop);
    wr_ptr_d   = flush ? '0 : wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d   = flush ? '0 : rd_ptr_q + PTR_W'(pop);
    level_d    = level_q;
    if (flush) begin
      level_d = '0;
    end else if (push_ok && !pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (pop && !push_ok) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= IDLE;
      addr_q       <= BASE_ADDR;
      cnt_q        <= '0;
      pend_q       <= 1'b0;
      vsync_q      <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      level_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      vsync_q      <= pix_vsync;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      level_q      <= level_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= pix_data;
  end

  assign mem_wr_req    = (state_q == REQ);
  assign mem_wr_addr   = addr_q;
  assign mem_wr_data   = (level_q == '0) ? 16'h0000 : mem_q[rd_ptr_q];
  assign fifo_level    = level_q;
  assign fifo_overflow = overflow_q;
  assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_cam_burst_writer.sv
// Directed bench for cam_burst_writer with a 128-word frame so wrap-around is reachable.
module tb_cam_burst_writer;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        pix_vsync, pix_wr_en, mem_wr_ack, mem_wr_data_rd;
  logic [15:0] pix_data;
  logic        mem_wr_req, fifo_overflow, frame_done;
  logic [23:0] mem_wr_addr;
  logic [15:0] mem_wr_data;
  logic [8:0]  fifo_level;

  int n_chk = 0;
  int n_pass = 0;

  cam_burst_writer #(
    .BURST_LEN(64), .FIFO_DEPTH(256), .ADDR_W(24), .BASE_ADDR(24'd0), .FRAME_PIXELS(128)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .pix_vsync(pix_vsync), .pix_wr_en(pix_wr_en), .pix_data(pix_data),
    .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_ack(mem_wr_ack),
    .mem_wr_data_rd(mem_wr_data_rd), .mem_wr_data(mem_wr_data),
    .fifo_level(fifo_level), .fifo_overflow(fifo_overflow), .frame_done(frame_done)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push_n(input int n, input logic [15:0] d0);
    for (int i = 0; i < n; i++) begin
      pix_wr_en = 1'b1;
      pix_data  = d0 + 16'(i);
      step();
    end
    pix_wr_en = 1'b0;
  endtask

  task automatic wait_req();
    int t = 0;
    while (!mem_wr_req && t < 20) begin
      step();
      t++;
    end
    chk("req_seen", mem_wr_req, 1);
  endtask

  task automatic grant();
    step();
    step();
    mem_wr_ack = 1'b1;
    step();
    mem_wr_ack = 1'b0;
    chk("req_drop_after_ack", mem_wr_req, 0);
  endtask

  // Serve one burst: ack 3 cycles after req, pop 64 words checking order.
  task automatic serve_burst(input logic [23:0] a, input logic [15:0] d0, input logic exp_done,
                             input logic [23:0] exp_next, input logic [8:0] exp_level,
                             input int vs_at);
    wait_req();
    chk("burst_addr", mem_wr_addr, a);
    grant();
    for (int i = 0; i < 64; i++) begin
      chk($sformatf("data[%0d]", i), mem_wr_data, d0 + 16'(i));
      mem_wr_data_rd = 1'b1;
      pix_vsync      = (i == vs_at);
      step();
    end
    mem_wr_data_rd = 1'b0;
    pix_vsync      = 1'b0;
    chk("frame_done_end", frame_done, exp_done);
    chk("next_addr", mem_wr_addr, exp_next);
    chk("level_after_burst", fifo_level, exp_level);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pix_vsync      = 1'($urandom);
      pix_wr_en      = 1'($urandom);
      pix_data       = 16'($urandom);
      mem_wr_ack     = 1'($urandom);
      mem_wr_data_rd = 1'($urandom);
      step();
    end
    chk("rst_req", mem_wr_req, 0);
    chk("rst_addr", mem_wr_addr, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf", fifo_overflow, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_data", mem_wr_data, 0);
    pix_vsync = 0; pix_wr_en = 0; pix_data = 0; mem_wr_ack = 0; mem_wr_data_rd = 0;
    step();
    sys_rst_n = 1'b1;
    step();

    // stray ack and pop in IDLE must do nothing
    mem_wr_ack = 1'b1; mem_wr_data_rd = 1'b1;
    step();
    mem_wr_ack = 1'b0; mem_wr_data_rd = 1'b0;
    step();
    chk("idle_ack_ignored", mem_wr_req, 0);

    // single burst
    push_n(64, 16'h0000);
    chk("level_64", fifo_level, 64);
    chk("req_not_yet", mem_wr_req, 0);
    step();
    chk("req_2_edges", mem_wr_req, 1);
    serve_burst(24'd0, 16'h0000, 1'b0, 24'd64, 9'd0, -1);

    // frame restart while idle
    pix_vsync = 1'b1;
    step();
    pix_vsync = 1'b0;
    step();
    step();
    chk("restart_addr", mem_wr_addr, 0);

    // frame wrap
    push_n(128, 16'h0100);
    chk("level_128", fifo_level, 128);
    serve_burst(24'd0, 16'h0100, 1'b0, 24'd64, 9'd64, -1);
    serve_burst(24'd64, 16'h0140, 1'b1, 24'd0, 9'd0, -1);
    step();
    chk("frame_done_one_cycle", frame_done, 0);

    // overflow with the controller never acking
    push_n(261, 16'h0200);
    chk("ovf_level", fifo_level, 256);
    chk("ovf_flag", fifo_overflow, 1);
    chk("ovf_head", mem_wr_data, 16'h0200);
    chk("ovf_req_held", mem_wr_req, 1);
    pix_vsync = 1'b1;
    step();
    chk("abort_req", mem_wr_req, 0);
    pix_vsync = 1'b0;
    step();
    chk("abort_level", fifo_level, 0);
    chk("abort_ovf", fifo_overflow, 0);
    chk("abort_addr", mem_wr_addr, 0);

    // vsync after 10 pops: burst still completes, then restart
    push_n(64, 16'h0300);
    serve_burst(24'd0, 16'h0300, 1'b0, 24'd64, 9'd0, 10);
    step();
    chk("midburst_vs_addr", mem_wr_addr, 0);
    chk("midburst_vs_level", fifo_level, 0);
    chk("midburst_vs_done", frame_done, 0);

    // reset in the middle of a burst
    push_n(64, 16'h0400);
    wait_req();
    grant();
    mem_wr_data_rd = 1'b1;
    for (int i = 0; i < 20; i++) step();
    mem_wr_data_rd = 1'b0;
    sys_rst_n = 1'b0;
    #1;
    chk("mrst_req", mem_wr_req, 0);
    chk("mrst_addr", mem_wr_addr, 0);
    chk("mrst_level", fifo_level, 0);
    chk("mrst_data", mem_wr_data, 0);
    step();
    step();
    sys_rst_n = 1'b1;
    step();
    push_n(64, 16'h0500);
    serve_burst(24'd0, 16'h0500, 1'b0, 24'd64, 9'd0, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
